// File: rtl/bp_fe_ras_pkg.sv
// Shared constants and width helpers for the front-end return address stack.
package bp_fe_ras_pkg;

  localparam int unsigned RasVaddrWidthDef = 39;
  localparam int unsigned RasElsDef        = 8;

  // Checkpoint layout is {ptr, cnt, top}; consumers store it opaquely.
  function automatic int unsigned ras_ckpt_width(input int unsigned vaddr_width,
                                                 input int unsigned els);
    return $clog2(els) + $clog2(els + 1) + vaddr_width;
  endfunction

endpackage

// File: rtl/bp_fe_ras.sv
// Return address stack: push on call, pop on return, swap on call+return, with
// exact checkpoint restore of pointer, occupancy and top entry on redirect.
module bp_fe_ras
  import bp_fe_ras_pkg::*;
#(
  parameter int unsigned vaddr_width_p = RasVaddrWidthDef,
  parameter int unsigned ras_els_p     = RasElsDef,
  localparam int unsigned ptr_width_lp  = $clog2(ras_els_p),
  localparam int unsigned cnt_width_lp  = $clog2(ras_els_p + 1),
  localparam int unsigned ckpt_width_lp = ras_ckpt_width(vaddr_width_p, ras_els_p)
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     call_v_i,
  input  logic [vaddr_width_p-1:0] call_addr_i,
  input  logic                     return_v_i,
  output logic                     tgt_v_o,
  output logic [vaddr_width_p-1:0] tgt_o,
  output logic [ckpt_width_lp-1:0] ckpt_o,
  input  logic                     restore_v_i,
  input  logic [ckpt_width_lp-1:0] restore_ckpt_i
);

  typedef struct packed {
    logic [ptr_width_lp-1:0]  ptr;
    logic [cnt_width_lp-1:0]  cnt;
    logic [vaddr_width_p-1:0] top;
  } ckpt_s;

  localparam logic [cnt_width_lp-1:0] CntFull = cnt_width_lp'(ras_els_p);

  logic [ptr_width_lp-1:0]  ptr_q, ptr_d;
  logic [cnt_width_lp-1:0]  cnt_q, cnt_d;
  logic [vaddr_width_p-1:0] mem_q [ras_els_p];

  logic                     mem_we;
  logic [ptr_width_lp-1:0]  mem_waddr;
  logic [vaddr_width_p-1:0] mem_wdata;
  logic [vaddr_width_p-1:0] top;
  logic                     empty;
  ckpt_s                    restore_ckpt;

  assign restore_ckpt = ckpt_s'(restore_ckpt_i);
  assign empty        = (cnt_q == '0);
  assign top          = mem_q[ptr_q];

  always_comb begin
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    mem_we    = 1'b0;
    mem_waddr = ptr_q;
    mem_wdata = call_addr_i;
    if (restore_v_i) begin
      // Rewriting the top slot undoes a wrong-path push onto it.
      ptr_d     = restore_ckpt.ptr;
      cnt_d     = restore_ckpt.cnt;
      mem_we    = 1'b1;
      mem_waddr = restore_ckpt.ptr;
      mem_wdata = restore_ckpt.top;
    end else if (call_v_i && return_v_i) begin
      mem_we = 1'b1;
      if (empty) begin
        ptr_d     = ptr_q + ptr_width_lp'(1);
        mem_waddr = ptr_q + ptr_width_lp'(1);
        cnt_d     = cnt_width_lp'(1);
      end
    end else if (call_v_i) begin
      ptr_d     = ptr_q + ptr_width_lp'(1);
      mem_waddr = ptr_q + ptr_width_lp'(1);
      mem_we    = 1'b1;
      if (cnt_q != CntFull) begin
        cnt_d = cnt_q + cnt_width_lp'(1);
      end
    end else if (return_v_i && !empty) begin
      ptr_d = ptr_q - ptr_width_lp'(1);
      cnt_d = cnt_q - cnt_width_lp'(1);
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage is deliberately not reset; occupancy alone marks validity.
  always_ff @(posedge clk_i) begin
    if (mem_we && !reset_i) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign tgt_v_o = !empty;
  assign tgt_o   = empty ? '0 : top;
  assign ckpt_o  = {ptr_q, cnt_q, top};

endmodule

// File: doc/bp_fe_ras.md
Name: bp_fe_ras

Overview:
- Return address stack for the front end.
- Consumes the call/return classification produced by the instruction scan:
  - pushes the link address on a call;
  - pops on a return;
  - presents the top entry as the predicted return target.
- Each prediction carries a checkpoint, so a backend redirect repairs speculative pushes and pops exactly.

Parameters:
- vaddr_width_p, 39, width of stored return addresses.
- ras_els_p, 8, stack depth. Must be a power of 2, at least 2.
- ptr_width_lp (local), $clog2(ras_els_p), top-of-stack index width.
- cnt_width_lp (local), $clog2(ras_els_p+1), occupancy width.
- ckpt_width_lp (local), ptr_width_lp+cnt_width_lp+vaddr_width_p, checkpoint width.

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; asynchronous, active-high
- call_v_i  in  1  scanned instruction is a call (scan call bit qualified by fetch valid)
- call_addr_i  in  vaddr_width_p  link address to push (pc+4, or pc+2 for compressed)
- return_v_i  in  1  scanned instruction is a return (scan _return bit qualified by fetch valid)
- tgt_v_o  out  1  stack non-empty; tgt_o is meaningful
- tgt_o  out  vaddr_width_p  top-of-stack return address
- ckpt_o  out  ckpt_width_lp  current state {ptr, cnt, top entry}, sampled with each prediction
- restore_v_i  in  1  redirect: restore the stack from restore_ckpt_i
- restore_ckpt_i  in  ckpt_width_lp  checkpoint captured with the mispredicted instruction

Behaviour:
- Reset (async, active-high):
  - ptr_r=0, cnt_r=0, so tgt_v_o=0.
  - tgt_o=0. It is gated to 0 whenever cnt_r==0.
  - Entry storage is not reset.
  - Reset mid-operation discards all entries and any in-flight restore.
- Storage: circular array of ras_els_p entries. ptr_r indexes the top entry.
- Outputs are combinational from state:
  - tgt_o = mem[ptr_r] when cnt_r!=0.
  - ckpt_o = {ptr_r, cnt_r, mem[ptr_r]}.
- Latency: a push or pop is visible on tgt_o/tgt_v_o the next cycle.
- Priority per cycle: restore_v_i > (call/return). Push/pop inputs are ignored when a restore occurs.
- Restore:
  - ptr_r<=ckpt.ptr, cnt_r<=ckpt.cnt.
  - mem[ckpt.ptr]<=ckpt.top. This repairs a top entry overwritten by a wrong-path push.
  - Deeper entries overwritten on the wrong path are not repaired; this is an accepted prediction inaccuracy.
- Push only (call_v_i & ~return_v_i):
  - ptr_r<=ptr_r+1 (mod ras_els_p); mem[ptr_r+1]<=call_addr_i.
  - cnt_r<=min(cnt_r+1, ras_els_p).
  - Full: the oldest entry is silently overwritten (wrap-around). cnt stays saturated.
- Pop only (return_v_i & ~call_v_i):
  - If cnt_r!=0: ptr_r<=ptr_r-1 (mod), cnt_r<=cnt_r-1.
  - Empty (underflow): no state change, tgt_v_o stays 0.
- Call and return together (coroutine swap, e.g. jalr rd=ra rs1=t0):
  - Pop-then-push: mem[ptr_r]<=call_addr_i; ptr_r and cnt_r unchanged.
  - If empty, behaves as a push: ptr_r<=ptr_r+1, write, cnt_r<=1.
- Pointer arithmetic is natural ptr_width_lp wraparound. No explicit modulo logic.
- No handshake backpressure: the block accepts one event per cycle, every cycle.

Decomposition:
- Shared defines:
  - bp_fe_ras_ckpt_s {ptr, cnt, top} goes in bp_fe_defines.svh as a declare macro parameterized by vaddr_width_p and ras_els_p, plus a width macro.
  - Consumers (fetch PC-gen, redirect queue) store it opaquely.
- No sub-module. Storage is a flop array with a single write port, muxed between restore, swap and push.
- Counter and pointer are bsg-style registers with async reset.

Test Plan:
- Reset: assert reset_i mid-stream after 3 pushes -> tgt_v_o=0, tgt_o=0 immediately; pop after release -> no change.
- LIFO: push 0x100, 0x204, 0x308 on consecutive cycles, then 3 pops:
  - tgt_o reads 0x308, 0x204, 0x100 across the pops;
  - tgt_v_o=0 after the third pop.
- Overflow (ras_els_p=8): push 0x10..0x90 (9 entries) -> cnt=8; 8 pops return 0x90 down to 0x20; a 9th pop is a no-op with tgt_v_o=0.
- Simultaneous: stack [0x100,0x200 top]; call_v_i=return_v_i=1 with addr 0x300 -> top=0x300, next pop exposes 0x100; on an empty stack the same stimulus leaves cnt=1, top=0x300.
- Restore: stack [0x100,0x200], capture ckpt_o; then pop, then push 0x999 (overwrites 0x200's slot), then restore_v_i with the ckpt -> tgt_o=0x200, cnt=2; next pop -> 0x100.
- Restore priority: restore_v_i with call_v_i=1 same cycle -> state equals checkpoint exactly; call ignored.
